// File: rtl/bus_mux_reg_if.sv
// Bus-side signal bundle for bus_mux_reg: the source enables and data come in,
// and the registered bus value and conflict debug state go out.
interface bus_mux_reg_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_out;
  logic                      conflict_clr;
  logic [DATA_W-1:0]         bus_out;
  logic [SEL_W-1:0]          bus_sel;
  logic                      bus_valid;
  logic                      conflict;
  logic                      conflict_sticky;
  logic [CNT_W-1:0]          conflict_cnt;

  // The control unit / datapath side: drives sources and enables.
  modport master (
    output src_data, src_out, conflict_clr,
    input  bus_out, bus_sel, bus_valid, conflict, conflict_sticky, conflict_cnt
  );

  // The multiplexer itself.
  modport slave (
    input  src_data, src_out, conflict_clr,
    output bus_out, bus_sel, bus_valid, conflict, conflict_sticky, conflict_cnt
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered shared-bus multiplexer. One-hot "out" enables are priority
// encoded (lowest index wins), the chosen source is registered onto the bus,
// and overlapping enables are flagged, latched and counted for debug.
module bus_mux_reg #(
  parameter int DATA_W    = 32,
  parameter int NUM_SRC   = 24,
  parameter int SEL_W     = 5,
  parameter bit HOLD_IDLE = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  bus_mux_reg_if.slave bus
);

  if ((2 ** SEL_W) < NUM_SRC) begin : g_sel_w_check
    $error("bus_mux_reg: SEL_W too narrow for NUM_SRC");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEL_W-1:0]  sel;
  logic              any_en;
  logic              multi;
  logic [DATA_W-1:0] sel_data;

  logic [DATA_W-1:0] bus_out_q,   bus_out_d;
  logic [SEL_W-1:0]  bus_sel_q,   bus_sel_d;
  logic              bus_valid_q, bus_valid_d;
  logic              conflict_q,  conflict_d;
  logic              sticky_q,    sticky_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // Priority encode the enables and detect more than one active driver.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel    = '0;
    any_en = 1'b0;
    multi  = 1'b0;
    // NOTE: blocking '=' here on purpose: each iteration must see the values
    // the previous one produced.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_out[i]) begin
        if (!any_en) sel = SEL_W'(i);
        multi  = multi | any_en;
        any_en = 1'b1;
      end
    end
  end

  // Select the winning source word; sel never exceeds NUM_SRC-1.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) sel_data = bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state for the bus register and the conflict debug state.
  always_comb begin
    bus_out_d   = bus_out_q;
    bus_sel_d   = bus_sel_q;
    bus_valid_d = any_en;
    conflict_d  = multi;
    sticky_d    = (sticky_q & ~bus.conflict_clr) | multi;
    cnt_d       = cnt_q;

    if (any_en) begin
      bus_out_d = sel_data;
      bus_sel_d = sel;
    end else if (!HOLD_IDLE) begin
      bus_out_d = '0;
    end

    // A new conflict wins over a simultaneous clear; the count never wraps.
    if (multi) begin
      if (bus.conflict_clr)    cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.conflict_clr) begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking '<=' for all flops so every register samples the
    // pre-edge values regardless of statement order.
    if (!clr_n) begin
      bus_out_q   <= '0;
      bus_sel_q   <= '0;
      bus_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bus_out_q   <= bus_out_d;
      bus_sel_q   <= bus_sel_d;
      bus_valid_q <= bus_valid_d;
      conflict_q  <= conflict_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.bus_out         = bus_out_q;
  assign bus.bus_sel         = bus_sel_q;
  assign bus.bus_valid       = bus_valid_q;
  assign bus.conflict        = conflict_q;
  assign bus.conflict_sticky = sticky_q;
  assign bus.conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: one instance holds the bus when idle, a
// second identical-stimulus instance drives zero when idle.
module tb_bus_mux_reg;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 24;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 8;

  logic clk;
  logic clr_n;
  int   n_chk;
  int   n_bad;

  bus_mux_reg_if #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bif_h ();
  bus_mux_reg_if #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bif_z ();

  assign bif_z.src_data     = bif_h.src_data;
  assign bif_z.src_out      = bif_h.src_out;
  assign bif_z.conflict_clr = bif_h.conflict_clr;

  bus_mux_reg #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
                .HOLD_IDLE(1'b1), .CNT_W(CNT_W)) u_hold (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif_h.slave)
  );

  bus_mux_reg #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
                .HOLD_IDLE(1'b0), .CNT_W(CNT_W)) u_zero (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif_z.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " h.bus_out"},   64'(bif_h.bus_out), 64'd0);
    chk({tag, " h.bus_sel"},   64'(bif_h.bus_sel), 64'd0);
    chk({tag, " h.valid"},     64'(bif_h.bus_valid), 64'd0);
    chk({tag, " h.conflict"},  64'(bif_h.conflict), 64'd0);
    chk({tag, " h.sticky"},    64'(bif_h.conflict_sticky), 64'd0);
    chk({tag, " h.cnt"},       64'(bif_h.conflict_cnt), 64'd0);
    chk({tag, " z.bus_out"},   64'(bif_z.bus_out), 64'd0);
    chk({tag, " z.valid"},     64'(bif_z.bus_valid), 64'd0);
    chk({tag, " z.cnt"},       64'(bif_z.conflict_cnt), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    clr_n = 1'b0;
    bif_h.conflict_clr = 1'b0;
    bif_h.src_out = '1;
    for (int i = 0; i < NUM_SRC; i++)
      bif_h.src_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i);

    // Reset held two cycles with every enable high.
    tick();
    tick();
    chk_all_zero("reset");

    // Release with no enables: still idle.
    bif_h.src_out = '0;
    clr_n = 1'b1;
    tick();
    chk("post_reset valid", 64'(bif_h.bus_valid), 64'd0);
    chk("post_reset bus",   64'(bif_h.bus_out), 64'd0);

    // Walking one across all sources, one new bus value every cycle.
    for (int i = 0; i < NUM_SRC; i++) begin
      bif_h.src_out = 24'(1) << i;
      tick();
      chk($sformatf("walk%0d bus", i),      64'(bif_h.bus_out), 64'(32'hA000_0000 + 32'(i)));
      chk($sformatf("walk%0d sel", i),      64'(bif_h.bus_sel), 64'(i));
      chk($sformatf("walk%0d valid", i),    64'(bif_h.bus_valid), 64'd1);
      chk($sformatf("walk%0d conflict", i), 64'(bif_h.conflict), 64'd0);
    end

    // Idle behaviour after MDR drove the bus.
    bif_h.src_data[21*DATA_W +: DATA_W] = 32'h1234_5678;
    bif_h.src_out = 24'(1) << 21;
    tick();
    chk("mdr bus", 64'(bif_h.bus_out), 64'h1234_5678);
    bif_h.src_out = '0;
    tick();
    chk("idle hold bus",   64'(bif_h.bus_out), 64'h1234_5678);
    chk("idle hold valid", 64'(bif_h.bus_valid), 64'd0);
    chk("idle hold sel",   64'(bif_h.bus_sel), 64'd21);
    chk("idle zero bus",   64'(bif_z.bus_out), 64'd0);
    chk("idle zero valid", 64'(bif_z.bus_valid), 64'd0);
    chk("idle zero sel",   64'(bif_z.bus_sel), 64'd21);

    // R3 and PC together for three cycles.
    bif_h.src_out = (24'(1) << 3) | (24'(1) << 20);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("conf%0d sel", c),  64'(bif_h.bus_sel), 64'd3);
      chk($sformatf("conf%0d bus", c),  64'(bif_h.bus_out), 64'hA000_0003);
      chk($sformatf("conf%0d flag", c), 64'(bif_h.conflict), 64'd1);
      chk($sformatf("conf%0d cnt", c),  64'(bif_h.conflict_cnt), 64'(c));
    end
    chk("conf sticky", 64'(bif_h.conflict_sticky), 64'd1);
    bif_h.src_out = 24'(1) << 5;
    tick();
    chk("single flag",   64'(bif_h.conflict), 64'd0);
    chk("single sticky", 64'(bif_h.conflict_sticky), 64'd1);
    chk("single cnt",    64'(bif_h.conflict_cnt), 64'd3);
    chk("single sel",    64'(bif_h.bus_sel), 64'd5);

    // Clear coinciding with a new conflict, then clear alone.
    bif_h.src_out = (24'(1) << 3) | (24'(1) << 20);
    bif_h.conflict_clr = 1'b1;
    tick();
    chk("clr+conf cnt",    64'(bif_h.conflict_cnt), 64'd1);
    chk("clr+conf sticky", 64'(bif_h.conflict_sticky), 64'd1);
    bif_h.src_out = '0;
    tick();
    chk("clr cnt",    64'(bif_h.conflict_cnt), 64'd0);
    chk("clr sticky", 64'(bif_h.conflict_sticky), 64'd0);
    bif_h.conflict_clr = 1'b0;

    // Saturation over 300 conflict cycles.
    bif_h.src_out = (24'(1) << 0) | (24'(1) << 23);
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c == 254) chk("sat 254", 64'(bif_h.conflict_cnt), 64'd254);
      if (c == 255) chk("sat 255", 64'(bif_h.conflict_cnt), 64'd255);
    end
    chk("sat end cnt", 64'(bif_h.conflict_cnt), 64'd255);
    chk("sat end sel", 64'(bif_h.bus_sel), 64'd0);

    // Mid-run reset discards everything in flight.
    clr_n = 1'b0;
    tick();
    chk_all_zero("midreset");
    clr_n = 1'b1;
    bif_h.src_out = '0;
    tick();
    chk("after midreset valid", 64'(bif_h.bus_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath's 24-source, 32-bit bus multiplexer.
- Accepts one-hot "out" enables from the control unit (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout).
- Encodes the enables internally and drives the shared bus through an output register.
- Adds hold/zero idle mode, multi-driver conflict detection, a sticky error flag and a saturating conflict counter for debug.

Parameters:
- DATA_W, 32, width of each source and of the bus.
- NUM_SRC, 24, number of bus sources; index 0 = R0 … 15 = R15, 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MDR, 22 = InPort, 23 = C.
- SEL_W, 5, encoded select width; must satisfy 2^SEL_W >= NUM_SRC.
- HOLD_IDLE, 1, 1 = bus keeps its last value when no source is enabled; 0 = bus drives zero.
- CNT_W, 8, conflict counter width.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  synchronous active-low reset.
- src_data  input  NUM_SRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
- src_out  input  NUM_SRC  per-source bus-drive enables, expected one-hot or zero.
- conflict_clr  input  1  clears conflict_sticky and conflict_cnt.
- bus_out  output  DATA_W  registered bus value.
- bus_sel  output  SEL_W  registered index of the driving source.
- bus_valid  output  1  registered; 1 when some source drove the bus in the previous cycle.
- conflict  output  1  registered one-cycle flag: more than one enable was high in the previous cycle.
- conflict_sticky  output  1  latched conflict indicator.
- conflict_cnt  output  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (clr_n = 0 at a rising edge) forces all outputs to 0.
  - Reset overrides every other input.
  - Reset applied mid-operation discards the in-flight bus value.
- Encoding is combinational each cycle.
  - sel = lowest index i with src_out[i] = 1 (fixed priority: R0 highest, C lowest).
  - any = OR of src_out.
  - multi = 1 when popcount(src_out) >= 2.
- Latency is exactly 1 cycle, from src_out/src_data sampled at edge k to bus_out/bus_sel/bus_valid/conflict valid after edge k.
- When any = 1:
  - bus_out <= source[sel]
  - bus_sel <= sel
  - bus_valid <= 1
- When any = 0:
  - bus_valid <= 0.
  - bus_sel holds its previous value.
  - bus_out holds its previous value if HOLD_IDLE = 1, else is set to 0.
- Conflict handling:
  - conflict <= multi; the bus still takes the lowest-index source.
  - conflict_sticky <= (conflict_sticky & ~conflict_clr) | multi.
  - conflict_cnt:
    - if multi and conflict_clr, the counter becomes 1;
    - if conflict_clr alone, it becomes 0;
    - if multi alone, it increments;
    - a new conflict wins over a simultaneous clear.
  - conflict_cnt saturates at 2^CNT_W - 1 and never wraps.
- Back-to-back different selects produce a new bus value every cycle; there are no bubbles.
- src_out bits at or above NUM_SRC do not exist. Select values at or above NUM_SRC are never produced.
- Source data is DATA_W wide with no extension or truncation. Sign-extension of C is the responsibility of the C-source logic, not this block.

Test Plan:
- Reset: clr_n = 0 for 2 cycles with src_out = 24'hFFFFFF -> all outputs 0; after release, bus_valid = 0 until the first enable.
- Walking one: set source i to 32'hA000_0000+i and walk src_out = 1<<i for i = 0..23 -> the cycle after each step, bus_out = A000_0000+i, bus_sel = i, bus_valid = 1, conflict = 0.
- Idle hold/zero: drive MDRout (index 21, data 32'h1234_5678), then src_out = 0 -> HOLD_IDLE = 1 gives bus_out = 32'h1234_5678 and bus_valid = 0; HOLD_IDLE = 0 gives bus_out = 0; bus_sel = 21 in both cases.
- Conflict: src_out has R3 and PC set (bits 3 and 20) for 3 cycles -> bus_sel = 3, conflict = 1 for 3 cycles, conflict_sticky = 1, conflict_cnt = 3; then a single enable -> conflict = 0, sticky stays 1.
- Clear vs. set: conflict_clr = 1 in the same cycle as a two-driver conflict -> conflict_cnt = 1 and sticky = 1; conflict_clr = 1 alone -> cnt = 0 and sticky = 0.
- Saturation and mid-run reset: hold a conflict for 300 cycles -> conflict_cnt stops at 255; then assert clr_n = 0 for one cycle -> all outputs return to 0 on the next edge.
